// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-754 divider: radix-2 restoring mantissa division, one quotient
// bit per clock, round-to-nearest-even, subnormals flushed to zero.
module fp_div_iter #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   res,
  output logic [3:0]             flags
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned N     = MAN_W + 3;
  localparam int unsigned CNT_W = $clog2(N);
  localparam int unsigned EW    = EXP_W + 2;
  localparam int unsigned RW    = MAN_W + 2;
  localparam int unsigned BIAS  = (2 ** (EXP_W - 1)) - 1;
  localparam int unsigned EMAX  = (2 ** EXP_W) - 1;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sign;
  logic [EW-1:0]      r_exp;
  logic [RW-1:0]      r_rem;
  logic [MAN_W:0]     r_mb;
  logic [N-1:0]       r_q;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_res;
  logic [3:0]         r_flags;

  // Operand classification
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic             w_sign_in, w_accept;

  assign w_ea      = a[W-2 -: EXP_W];
  assign w_eb      = b[W-2 -: EXP_W];
  assign w_fa      = a[MAN_W-1:0];
  assign w_fb      = b[MAN_W-1:0];
  assign w_a_zero  = (w_ea == '0);
  assign w_b_zero  = (w_eb == '0);
  assign w_a_inf   = (&w_ea) && (w_fa == '0);
  assign w_b_inf   = (&w_eb) && (w_fb == '0);
  assign w_a_nan   = (&w_ea) && (w_fa != '0);
  assign w_b_nan   = (&w_eb) && (w_fb != '0);
  assign w_sign_in = a[W-1] ^ b[W-1];
  assign w_accept  = in_valid && (r_state == S_IDLE);

  // Special-case results, checked in priority order
  logic           w_special;
  logic [W-1:0]   w_spec_res;
  logic [3:0]     w_spec_flags;

  always_comb begin
    w_special    = 1'b1;
    w_spec_res   = '0;
    w_spec_flags = '0;
    if (w_a_nan || w_b_nan) begin
      w_spec_res = QNAN;
    end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res   = QNAN;
      w_spec_flags = 4'b1000;
    end else if (w_b_zero && !w_a_inf) begin
      w_spec_res   = {w_sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_spec_flags = 4'b0100;
    end else if (w_a_inf) begin
      w_spec_res = {w_sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_b_inf || w_a_zero) begin
      w_spec_res = {w_sign_in, {(W-1){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  // Restoring divide step
  logic          w_ge;
  logic [RW-1:0] w_rem_sub;

  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  // Normalise, round to nearest even, range check
  logic [N-2:0]   w_qn;
  logic [EW-1:0]  w_en;
  logic           w_guard, w_sticky, w_round_up;
  logic [MAN_W:0] w_frac_rnd;
  logic [EW-1:0]  w_e_fin;
  logic [W-1:0]   w_norm_res;
  logic [3:0]     w_norm_flags;

  assign w_qn       = r_q[N-1] ? r_q[N-2:0] : {r_q[N-3:0], 1'b0};
  assign w_en       = r_q[N-1] ? r_exp : (r_exp - EW'(1));
  assign w_guard    = w_qn[1];
  assign w_sticky   = w_qn[0] | (r_rem != '0);
  assign w_round_up = w_guard & (w_sticky | w_qn[2]);
  assign w_frac_rnd = {1'b0, w_qn[N-2:2]} + (MAN_W+1)'(w_round_up);
  assign w_e_fin    = w_en + EW'(w_frac_rnd[MAN_W]);

  always_comb begin
    w_norm_res   = {r_sign, w_e_fin[EXP_W-1:0], w_frac_rnd[MAN_W-1:0]};
    w_norm_flags = '0;
    if ($signed(w_e_fin) >= $signed(EW'(EMAX))) begin
      w_norm_res   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_norm_flags = 4'b0010;
    end else if (w_e_fin[EW-1] || (w_e_fin == '0)) begin
      w_norm_res   = {r_sign, {(W-1){1'b0}}};
      w_norm_flags = 4'b0001;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = w_special ? S_DONE : S_DIV;
      S_DIV:  if (r_cnt == CNT_W'(N - 1)) w_state_nxt = S_NORM;
      S_NORM: w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_rem   <= '0;
      r_mb    <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_sign <= w_sign_in;
          r_exp  <= EW'(w_ea) - EW'(w_eb) + EW'(BIAS);
          r_rem  <= {1'b0, 1'b1, w_fa};
          r_mb   <= {1'b1, w_fb};
          r_q    <= '0;
          r_cnt  <= '0;
          if (w_special) begin
            r_res   <= w_spec_res;
            r_flags <= w_spec_flags;
          end
        end
        S_DIV: begin
          r_rem <= {w_rem_sub[RW-2:0], 1'b0};
          r_q   <= {r_q[N-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_NORM: begin
          r_res   <= w_norm_res;
          r_flags <= w_norm_flags;
        end
        default: ;
      endcase
    end
  end

  assign res   = r_res;
  assign flags = r_flags;

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: directed vectors, randomised operands against an
// exact-arithmetic reference, back-pressure hold and mid-operation reset.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [3:0]  flags;

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   first_cyc = 0;
  bit   prev_v = 1'b0;
  int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_v) first_cyc = cyc;
    prev_v = out_valid;
    if (!rst && out_valid && out_ready) begin
      n_out++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output res=%08h flags=%04b (no result expected)", res, flags);
      end else begin
        e = sb.pop_front();
        if (res !== e.res || flags !== e.flags) begin
          errors++;
          $display("FAIL result got res=%08h flags=%04b expected res=%08h flags=%04b",
                   res, flags, e.res, e.flags);
        end
        checks++;
        if (first_cyc - e.acc != e.lat) begin
          errors++;
          $display("FAIL latency got %0d expected %0d", first_cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Reference: exact rational division rounded to nearest even
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    int ex, ey, e;
    longint fx, fy, ma, mb, num, q, rm;
    bit s, xz, yz, xi, yi, xn, yn;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    fx = longint'(x[22:0]); fy = longint'(y[22:0]);
    s  = x[31] ^ y[31];
    xz = (ex == 0); yz = (ey == 0);
    xi = (ex == 255) && (fx == 0); yi = (ey == 255) && (fy == 0);
    xn = (ex == 255) && (fx != 0); yn = (ey == 255) && (fy != 0);
    r.flags = 4'b0000; r.lat = 0; r.acc = 0;
    if (xn || yn)                        r.res = 32'h7FC00000;
    else if ((xz && yz) || (xi && yi)) begin r.res = 32'h7FC00000; r.flags = 4'b1000; end
    else if (yz && !xi)                begin r.res = {s, 31'h7F800000}; r.flags = 4'b0100; end
    else if (xi)                         r.res = {s, 31'h7F800000};
    else if (yi || xz)                   r.res = {s, 31'h0};
    else begin
      r.lat = 27;
      ma = (64'd1 << 23) + fx;
      mb = (64'd1 << 23) + fy;
      e  = ex - ey + 127;
      if (ma < mb) begin num = ma << 24; e = e - 1; end
      else         num = ma << 23;
      q  = num / mb;
      rm = num % mb;
      if ((2 * rm > mb) || ((2 * rm == mb) && (q % 2 == 1))) q = q + 1;
      if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e = e + 1; end
      if (e >= 255)    begin r.res = {s, 31'h7F800000}; r.flags = 4'b0010; end
      else if (e <= 0) begin r.res = {s, 31'h0};        r.flags = 4'b0001; end
      else             r.res = {s, 8'(e), 23'(q)};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] t;
    logic [7:0]  e;
    t = $urandom;
    case ($urandom_range(0, 15))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    if ($urandom_range(0, 7) == 0) t[22:0] = '0;
    return {t[31], e, t[22:0]};
  endfunction

  // Present one operand pair; optionally push its expected response
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v,
                      input exp_t ex, input bit push);
    int guard = 0;
    @(posedge clk); #1;
    a = ta; b = tb_v; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 500) begin
        errors++; checks++;
        $display("FAIL accept_timeout in_ready never rose");
        break;
      end
    end
    ex.acc = cyc + 1;
    if (push) sb.push_back(ex);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic send_exp(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] er, input logic [3:0] ef, input int el);
    exp_t ex;
    ex.res = er; ex.flags = ef; ex.lat = el; ex.acc = 0;
    send(ta, tb_v, ex, 1'b1);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 || out_valid) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        errors++; checks++;
        $display("FAIL drain_timeout pending=%0d", sb.size());
        break;
      end
    end
  endtask

  initial begin
    int n_before;
    int guard;
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 32'h0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_state got in_ready=%b out_valid=%b res=%08h flags=%04b expected 1 0 00000000 0000",
               in_ready, out_valid, res, flags);
    end

    // Directed vectors
    send_exp(32'h3F800000, 32'h40000000, 32'h3F000000, 4'b0000, 27);
    send_exp(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27);
    send_exp(32'h40C00000, 32'hC0000000, 32'hC0400000, 4'b0000, 27);
    send_exp(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 0);
    send_exp(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
    send_exp(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 27);
    send_exp(32'h00800000, 32'h4B000000, 32'h00000000, 4'b0001, 27);
    send_exp(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 0);
    send_exp(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 0);
    send_exp(32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 0);
    send_exp(32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 0);
    send_exp(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 0);
    send_exp(32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 0);
    send_exp(32'hFF800000, 32'h00000000, 32'hFF800000, 4'b0000, 0);
    drain();

    // Randomised operands with random back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rb;
      ra = rand_op();
      rb = rand_op();
      send(ra, rb, model(ra, rb), 1'b1);
    end
    drain();

    // Hold result under back-pressure; a new request must not be taken
    rdy_mode = 1;
    @(posedge clk);
    send_exp(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 27);
    #1 in_valid = 1'b1; a = 32'h40000000; b = 32'h3F800000;
    guard = 0;
    while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL hold_valid_timeout out_valid=%b expected 1", out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (res !== 32'h3EAAAAAB || flags !== 4'b0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable got res=%08h flags=%04b out_valid=%b in_ready=%b expected 3eaaaaab 0000 1 0",
                 res, flags, out_valid, in_ready);
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    n_before = n_out;
    rdy_mode = 0;
    drain();
    repeat (40) @(negedge clk);
    checks++;
    if (n_out != n_before + 1) begin
      errors++;
      $display("FAIL hold_outputs got %0d outputs expected %0d", n_out - n_before, 1);
    end

    // Reset while dividing: op is dropped
    n_before = n_out;
    begin
      exp_t dummy;
      dummy = model(32'h3F800000, 32'h40400000);
      send(32'h3F800000, 32'h40400000, dummy, 1'b0);
    end
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (n_out != n_before) begin
      errors++;
      $display("FAIL reset_no_output got %0d outputs expected 0", n_out - n_before);
    end

    // Unit still works after the abort
    send_exp(32'h40C00000, 32'hC0000000, 32'hC0400000, 4'b0000, 27);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
